// File: rtl/rolling_variance.sv
// Rolling population variance over the last WINDOW price samples.
// Ports: i_valid/o_ready sample in, o_sqrt_start/i_sqrt_busy/o_rad radicand out, o_filled, o_sat.
module rolling_variance #(
    parameter int WIDTH       = 32,
    parameter int FRACT_BITS  = 16,
    parameter int LOG2_WINDOW = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_price,
    output logic             o_sqrt_start,
    input  logic             i_sqrt_busy,
    output logic [WIDTH-1:0] o_rad,
    output logic             o_filled,
    output logic             o_sat
);

    localparam int WINDOW = 1 << LOG2_WINDOW;
    localparam int CW     = LOG2_WINDOW + 1;
    localparam int SW     = WIDTH + LOG2_WINDOW;
    localparam int PW     = 2 * WIDTH;
    localparam int QW     = PW + LOG2_WINDOW;

    localparam logic [CW-1:0]          CNT_FULL = CW'(WINDOW);
    localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
    localparam logic [LOG2_WINDOW-1:0] PTR_ONE  = LOG2_WINDOW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_CALC,
        S_ISSUE
    } state_t;

    state_t                 r_state;
    logic                   r_ready;
    logic [WIDTH-1:0]       r_buf [WINDOW];
    logic [LOG2_WINDOW-1:0] r_wr_ptr;
    logic [CW-1:0]          r_count;
    logic [WIDTH-1:0]       r_new;
    logic [WIDTH-1:0]       r_old;
    logic [SW-1:0]          r_sum;
    logic [QW-1:0]          r_sumsq;

    logic             w_accept;
    logic             w_full;
    logic [PW-1:0]    w_new_sq;
    logic [PW-1:0]    w_old_sq;
    logic [WIDTH-1:0] w_mean;
    logic [PW-1:0]    w_mean_sq;
    logic [PW-1:0]    w_ex2;
    logic [PW:0]      w_diff;
    logic [PW-1:0]    w_var;
    logic             w_ovf;

    assign o_ready  = r_ready;
    assign w_accept = i_valid && r_ready;
    assign w_full   = (r_count == CNT_FULL);

    assign w_new_sq  = PW'(r_new) * PW'(r_new);
    assign w_old_sq  = PW'(r_old) * PW'(r_old);
    assign w_mean    = WIDTH'(r_sum >> LOG2_WINDOW);
    assign w_mean_sq = PW'(w_mean) * PW'(w_mean);
    assign w_ex2     = PW'(r_sumsq >> LOG2_WINDOW);
    // Guard bit catches E[x^2] < mean^2 caused by flooring both terms.
    assign w_diff    = {1'b0, w_ex2} - {1'b0, w_mean_sq};
    assign w_var     = w_diff[PW] ? '0 : (w_diff[PW-1:0] >> FRACT_BITS);
    assign w_ovf     = |w_var[PW-1:WIDTH];

    // Sample storage is data only; contents before fill are masked by r_count.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buf[r_wr_ptr] <= i_price;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_new        <= '0;
            r_old        <= '0;
            r_sum        <= '0;
            r_sumsq      <= '0;
            o_sqrt_start <= 1'b0;
            o_rad        <= '0;
            o_filled     <= 1'b0;
            o_sat        <= 1'b0;
        end else begin
            o_sqrt_start <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_new    <= i_price;
                        r_old    <= w_full ? r_buf[r_wr_ptr] : '0;
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        if (!w_full) begin
                            r_count <= r_count + CNT_ONE;
                        end
                        r_ready <= 1'b0;
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_sum   <= r_sum + SW'(r_new) - SW'(r_old);
                    r_sumsq <= r_sumsq + QW'(w_new_sq) - QW'(w_old_sq);
                    if (w_full) begin
                        o_filled <= 1'b1;
                        r_state  <= S_CALC;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    o_rad   <= w_ovf ? '1 : w_var[WIDTH-1:0];
                    o_sat   <= w_ovf;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!i_sqrt_busy) begin
                        o_sqrt_start <= 1'b1;
                        r_ready      <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rolling_variance.sv
// Bench for rolling_variance: directed and random samples vs a window model.
// Ports: drives all DUT inputs, checks every output.
module tb_rolling_variance;

    localparam int WIN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_price = '0;
    logic        o_sqrt_start;
    logic        i_sqrt_busy = 1'b0;
    logic [31:0] o_rad;
    logic        o_filled;
    logic        o_sat;

    int errors = 0;
    int checks = 0;

    logic [31:0] win[$];
    bit          filled_m = 1'b0;

    always #5 clk = ~clk;

    rolling_variance #(
        .WIDTH(32),
        .FRACT_BITS(16),
        .LOG2_WINDOW(2)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_price     (i_price),
        .o_sqrt_start(o_sqrt_start),
        .i_sqrt_busy (i_sqrt_busy),
        .o_rad       (o_rad),
        .o_filled    (o_filled),
        .o_sat       (o_sat)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Population variance of the window, floored at each step, Q16.16.
    task automatic model(output logic [31:0] rad, output logic sat);
        logic [127:0] s, sq, x, m, e, d;
        s  = '0;
        sq = '0;
        foreach (win[i]) begin
            x  = 128'(win[i]);
            s  = s + x;
            sq = sq + x * x;
        end
        m = s / WIN;
        e = sq / WIN;
        d = (e < m * m) ? 128'd0 : (e - m * m);
        d = d / 65536;
        sat = (d > 128'hFFFF_FFFF);
        rad = sat ? 32'hFFFF_FFFF : d[31:0];
    endtask

    task automatic push(input logic [31:0] p, output bit iss);
        win.push_back(p);
        if (win.size() > WIN) void'(win.pop_front());
        iss = (win.size() == WIN);
        if (iss) filled_m = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 64'(o_ready), 64'd1);
    endtask

    task automatic send(input logic [31:0] p, input string tag,
                        output logic [31:0] rad);
        int first;
        int pulses;
        bit iss;
        logic [31:0] er;
        logic es;
        wait_ready(tag);
        i_price = p;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        push(p, iss);
        first  = 0;
        pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (o_sqrt_start) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        chk({tag, "_filled"}, 64'(o_filled), 64'(filled_m));
        if (iss) begin
            model(er, es);
            chk({tag, "_pulses"}, 64'(pulses), 64'd1);
            chk({tag, "_latency"}, 64'(first), 64'd3);
            chk({tag, "_rad"}, 64'(o_rad), 64'(er));
            chk({tag, "_sat"}, 64'(o_sat), 64'(es));
        end else begin
            chk({tag, "_nostart"}, 64'(pulses), 64'd0);
        end
        rad = o_rad;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] hold;
        logic [31:0] er;
        logic es;
        bit iss;
        int pulses;

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_start", 64'(o_sqrt_start), 64'd0);
        chk("rst_rad", 64'(o_rad), 64'd0);
        chk("rst_filled", 64'(o_filled), 64'd0);
        chk("rst_sat", 64'(o_sat), 64'd0);
        rst_n = 1'b1;

        // warm-up with constant 1.0
        for (int i = 0; i < 4; i++) send(32'h0001_0000, "warm", r);
        chk("warm_const", 64'(r), 64'd0);

        // known variance 1.0
        send(32'h0001_0000, "kv0", r);
        send(32'h0003_0000, "kv1", r);
        send(32'h0001_0000, "kv2", r);
        send(32'h0003_0000, "kv3", r);
        chk("known_var", 64'(r), 64'h0001_0000);
        chk("known_sat", 64'(o_sat), 64'd0);

        // wrap-around
        send(32'h0005_0000, "wrap5", r);
        chk("wrap5_val", 64'(r), 64'h0002_0000);
        send(32'h0007_0000, "wrap7", r);
        chk("wrap7_val", 64'(r), 64'h0005_0000);

        // backpressure: sqrt busy across the issue slot
        wait_ready("bp");
        i_sqrt_busy = 1'b1;
        i_price = 32'h0009_0000;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        push(32'h0009_0000, iss);
        model(er, es);
        @(negedge clk);
        @(negedge clk);
        hold = o_rad;
        chk("bp_rad", 64'(hold), 64'(er));
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                i_price = 32'h1234_0000;
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            chk("bp_ready", 64'(o_ready), 64'd0);
            chk("bp_start", 64'(o_sqrt_start), 64'd0);
            chk("bp_stable", 64'(o_rad), 64'(hold));
        end
        i_valid = 1'b0;
        i_sqrt_busy = 1'b0;
        @(negedge clk);
        chk("bp_fire", 64'(o_sqrt_start), 64'd1);
        @(negedge clk);
        chk("bp_once", 64'(o_sqrt_start), 64'd0);
        // stalled valid must not have entered the window
        send(32'h0002_0000, "bp_next", r);

        // saturation then recovery
        send(32'h0000_0000, "sat0", r);
        send(32'hFFFF_0000, "sat1", r);
        send(32'h0000_0000, "sat2", r);
        send(32'hFFFF_0000, "sat3", r);
        chk("sat_rad", 64'(r), 64'hFFFF_FFFF);
        chk("sat_flag", 64'(o_sat), 64'd1);
        for (int i = 0; i < 4; i++) send(32'h0001_0000, "unsat", r);
        chk("unsat_rad", 64'(r), 64'd0);
        chk("unsat_flag", 64'(o_sat), 64'd0);

        // random samples, mostly in a non-saturating range
        for (int i = 0; i < 16; i++) begin
            if (i % 5 == 4) send($urandom, "rnd_full", r);
            else send(32'($urandom_range(0, 32'h00FF_FFFF)), "rnd", r);
        end

        // reset in the CALC cycle
        wait_ready("mid");
        i_price = 32'h0004_0000;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_filled", 64'(o_filled), 64'd0);
        chk("mid_ready", 64'(o_ready), 64'd0);
        chk("mid_rad", 64'(o_rad), 64'd0);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (o_sqrt_start) pulses++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_sqrt_start) pulses++;
        end
        chk("mid_nostart", 64'(pulses), 64'd0);
        win.delete();
        filled_m = 1'b0;
        send(32'h0002_0000, "post0", r);
        send(32'h0004_0000, "post1", r);
        send(32'h0006_0000, "post2", r);
        send(32'h0008_0000, "post3", r);
        chk("post_val", 64'(r), 64'h0005_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
